// File: rtl/cpu_regfile_pkg.sv
// rtl/cpu_regfile_pkg.sv - register/pair index constants shared by the register file
package cpu_regfile_pkg;

    localparam int REG_B = 0;
    localparam int REG_C = 1;
    localparam int REG_D = 2;
    localparam int REG_E = 3;
    localparam int REG_H = 4;
    localparam int REG_L = 5;
    localparam int REG_F = 6;
    localparam int REG_A = 7;

    localparam int PAIR_BC = 0;
    localparam int PAIR_DE = 1;
    localparam int PAIR_HL = 2;
    localparam int PAIR_AF = 3;

    localparam logic INCDEC_INC = 1'b0;
    localparam logic INCDEC_DEC = 1'b1;

    function automatic int pair_of(input int reg_idx);
        return reg_idx / 2;
    endfunction

endpackage

// File: rtl/cpu_regfile_if.sv
// rtl/cpu_regfile_if.sv - read/write port bundle between control unit and register file
interface cpu_regfile_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8
);
    localparam int AW = $clog2(NREGS);
    localparam int PW = (AW > 1) ? AW - 1 : 1;

    logic [AW-1:0]        rd_a_sel;
    logic [WIDTH-1:0]     rd_a;
    logic [AW-1:0]        rd_b_sel;
    logic [WIDTH-1:0]     rd_b;
    logic [PW-1:0]        rdp_sel;
    logic [2*WIDTH-1:0]   rdp;
    logic                 wr_en;
    logic [AW-1:0]        wr_sel;
    logic [WIDTH-1:0]     wr_data;
    logic                 wrp_en;
    logic [PW-1:0]        wrp_sel;
    logic [2*WIDTH-1:0]   wrp_data;
    logic                 inc_en;
    logic [PW-1:0]        inc_sel;
    logic                 inc_dec;
    logic                 inc_drop;

    modport master (
        output rd_a_sel, rd_b_sel, rdp_sel,
        output wr_en, wr_sel, wr_data,
        output wrp_en, wrp_sel, wrp_data,
        output inc_en, inc_sel, inc_dec,
        input  rd_a, rd_b, rdp, inc_drop
    );

    modport slave (
        input  rd_a_sel, rd_b_sel, rdp_sel,
        input  wr_en, wr_sel, wr_data,
        input  wrp_en, wrp_sel, wrp_data,
        input  inc_en, inc_sel, inc_dec,
        output rd_a, rd_b, rdp, inc_drop
    );

endinterface

// File: rtl/cpu_regfile_pair.sv
// rtl/cpu_regfile_pair.sv - one register pair: write priority, masking and inc/dec
module cpu_regfile_pair
    import cpu_regfile_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] HI_MASK = '1,
    parameter logic [WIDTH-1:0] LO_MASK = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrp_en,
    input  logic [2*WIDTH-1:0] wrp_data,
    input  logic               wr_hi_en,
    input  logic               wr_lo_en,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               inc_en,
    input  logic               inc_dec,
    output logic [2*WIDTH-1:0] q,
    output logic [2*WIDTH-1:0] nxt,
    output logic               conflict
);
    localparam logic [2*WIDTH-1:0] ONE = 1;

    logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d, hi_new, lo_new;
    logic [2*WIDTH-1:0] cur, step;

    always_comb begin
        cur      = {hi_q, lo_q};
        step     = (inc_dec == INCDEC_DEC) ? cur - ONE : cur + ONE;
        conflict = inc_en & (wrp_en | wr_hi_en | wr_lo_en);
        hi_new   = hi_q;
        lo_new   = lo_q;
        if (wrp_en) begin
            {hi_new, lo_new} = wrp_data;
        end else if (inc_en && !conflict) begin
            {hi_new, lo_new} = step;
        end else begin
            // a conflicting inc/dec is dropped whole; only the byte writes land
            if (wr_hi_en) hi_new = wr_data;
            if (wr_lo_en) lo_new = wr_data;
        end
        hi_d = hi_new & HI_MASK;
        lo_d = lo_new & LO_MASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign q   = {hi_q, lo_q};
    assign nxt = {hi_d, lo_d};

endmodule

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - byte/pair register file with inc/dec and optional write-through reads
module cpu_regfile
    import cpu_regfile_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               NREGS     = 8,
    parameter int               FLAG_IDX  = 6,
    parameter logic [WIDTH-1:0] FLAG_MASK = 8'hF0,
    parameter bit               BYPASS    = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    cpu_regfile_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int PW = (AW > 1) ? AW - 1 : 1;
    localparam int NP = NREGS / 2;

    logic [WIDTH-1:0] cur_r  [NREGS];
    logic [WIDTH-1:0] nxt_r  [NREGS];
    logic [WIDTH-1:0] view_r [NREGS];
    logic [NP-1:0]    conflict;
    logic             inc_drop_q, inc_drop_d;
    logic [AW-1:0]    rdp_hi_idx, rdp_lo_idx;

    for (genvar p = 0; p < NP; p++) begin : g_pair
        localparam logic [WIDTH-1:0] HM = (2*p   == FLAG_IDX) ? FLAG_MASK : '1;
        localparam logic [WIDTH-1:0] LM = (2*p+1 == FLAG_IDX) ? FLAG_MASK : '1;

        logic [2*WIDTH-1:0] q, nx;

        cpu_regfile_pair #(
            .WIDTH   (WIDTH),
            .HI_MASK (HM),
            .LO_MASK (LM)
        ) u_pair (
            .clk      (clk),
            .rst      (rst),
            .wrp_en   (bus.wrp_en && (bus.wrp_sel == PW'(p))),
            .wrp_data (bus.wrp_data),
            .wr_hi_en (bus.wr_en && (bus.wr_sel == AW'(2*p))),
            .wr_lo_en (bus.wr_en && (bus.wr_sel == AW'(2*p+1))),
            .wr_data  (bus.wr_data),
            .inc_en   (bus.inc_en && (bus.inc_sel == PW'(p))),
            .inc_dec  (bus.inc_dec),
            .q        (q),
            .nxt      (nx),
            .conflict (conflict[p])
        );

        assign cur_r[2*p]   = q[2*WIDTH-1:WIDTH];
        assign cur_r[2*p+1] = q[WIDTH-1:0];
        assign nxt_r[2*p]   = nx[2*WIDTH-1:WIDTH];
        assign nxt_r[2*p+1] = nx[WIDTH-1:0];
    end

    // during reset nothing will be stored, so the write-through view is held at zero too
    for (genvar i = 0; i < NREGS; i++) begin : g_view
        assign view_r[i] = (BYPASS && !rst) ? nxt_r[i] : cur_r[i];
    end

    assign rdp_hi_idx = AW'({bus.rdp_sel, 1'b0});
    assign rdp_lo_idx = AW'({bus.rdp_sel, 1'b1});

    assign bus.rd_a     = view_r[bus.rd_a_sel];
    assign bus.rd_b     = view_r[bus.rd_b_sel];
    assign bus.rdp      = {view_r[rdp_hi_idx], view_r[rdp_lo_idx]};
    assign bus.inc_drop = inc_drop_q;

    always_comb begin
        inc_drop_d = |conflict;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) inc_drop_q <= 1'b0;
        else     inc_drop_q <= inc_drop_d;
    end

endmodule

// File: tb/tb_cpu_regfile.sv
// tb/tb_cpu_regfile.sv - directed self-checking bench for cpu_regfile
module tb_cpu_regfile;
    import cpu_regfile_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    cpu_regfile_if #(.WIDTH(8), .NREGS(8)) bus0 ();
    cpu_regfile_if #(.WIDTH(8), .NREGS(8)) bus1 ();

    cpu_regfile #(.WIDTH(8), .NREGS(8), .FLAG_IDX(6), .FLAG_MASK(8'hF0), .BYPASS(1'b0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    cpu_regfile #(.WIDTH(8), .NREGS(8), .FLAG_IDX(6), .FLAG_MASK(8'hF0), .BYPASS(1'b1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus0.wr_en = 1'b0; bus0.wrp_en = 1'b0; bus0.inc_en = 1'b0; bus0.inc_dec = INCDEC_INC;
        bus1.wr_en = 1'b0; bus1.wrp_en = 1'b0; bus1.inc_en = 1'b0; bus1.inc_dec = INCDEC_INC;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus0.rd_a_sel = 3'd0; bus0.rdp_sel = 2'd3; bus0.rd_b_sel = 3'd7;
        #1;
        n_checks++;
        if (bus0.rdp !== 16'h0000 || bus0.rd_a !== 8'h00 || bus0.inc_drop !== 1'b0) begin
            n_fail++; $display("FAIL reset_init: rdp %h rd_a %h drop %b, want 0000 00 0", bus0.rdp, bus0.rd_a, bus0.inc_drop);
        end
        #11 rst = 1'b0;
        tick();
        for (int p = 0; p < 4; p++) begin
            bus0.wrp_en = 1'b1; bus0.wrp_sel = 2'(p); bus0.wrp_data = 16'hAAAA;
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (bus0.rdp !== 16'hA0AA) begin
            n_fail++; $display("FAIL reset_load_af: got %h want a0aa", bus0.rdp);
        end
        n_checks++;
        if (bus0.rd_a !== 8'hAA) begin
            n_fail++; $display("FAIL reset_load_b: got %h want aa", bus0.rd_a);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (bus0.rd_a !== 8'h00 || bus0.rd_b !== 8'h00 || bus0.rdp !== 16'h0000 || bus0.inc_drop !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: rd_a %h rd_b %h rdp %h drop %b, want zeros", bus0.rd_a, bus0.rd_b, bus0.rdp, bus0.inc_drop);
        end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_byte_pair();
        bus0.wrp_en = 1'b1; bus0.wrp_sel = 2'(PAIR_HL); bus0.wrp_data = 16'h1234;
        tick();
        idle();
        bus0.wr_en = 1'b1; bus0.wr_sel = 3'(REG_L); bus0.wr_data = 8'h56;
        tick();
        idle();
        bus0.rdp_sel = 2'(PAIR_HL); bus0.rd_a_sel = 3'(REG_H); bus0.rd_b_sel = 3'(REG_L);
        #1;
        n_checks++;
        if (bus0.rdp !== 16'h1256) begin
            n_fail++; $display("FAIL byte_pair_rdp: got %h want 1256", bus0.rdp);
        end
        n_checks++;
        if (bus0.rd_a !== 8'h12 || bus0.rd_b !== 8'h56) begin
            n_fail++; $display("FAIL byte_pair_rd: rd_a %h rd_b %h want 12 56", bus0.rd_a, bus0.rd_b);
        end
    endtask

    task automatic test_wrap();
        bus0.wrp_en = 1'b1; bus0.wrp_sel = 2'(PAIR_HL); bus0.wrp_data = 16'hFFFF;
        tick();
        idle();
        bus0.inc_en = 1'b1; bus0.inc_sel = 2'(PAIR_HL); bus0.inc_dec = INCDEC_INC;
        tick();
        bus0.rdp_sel = 2'(PAIR_HL);
        #1;
        n_checks++;
        if (bus0.rdp !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_inc: got %h want 0000", bus0.rdp);
        end
        bus0.inc_dec = INCDEC_DEC;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus0.rdp !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_dec: got %h want ffff", bus0.rdp);
        end
        bus0.wrp_en = 1'b1; bus0.wrp_sel = 2'(PAIR_DE); bus0.wrp_data = 16'h00FF;
        tick();
        idle();
        bus0.inc_en = 1'b1; bus0.inc_sel = 2'(PAIR_DE);
        tick();
        idle();
        bus0.rdp_sel = 2'(PAIR_DE);
        #1;
        n_checks++;
        if (bus0.rdp !== 16'h0100) begin
            n_fail++; $display("FAIL wrap_carry: got %h want 0100", bus0.rdp);
        end
    endtask

    task automatic test_conflict();
        bus0.wrp_en = 1'b1; bus0.wrp_sel = 2'(PAIR_HL); bus0.wrp_data = 16'h1000;
        tick();
        idle();
        bus0.inc_en = 1'b1; bus0.inc_sel = 2'(PAIR_HL);
        bus0.wr_en = 1'b1; bus0.wr_sel = 3'(REG_H); bus0.wr_data = 8'h77;
        tick();
        idle();
        bus0.rdp_sel = 2'(PAIR_HL);
        #1;
        n_checks++;
        if (bus0.rdp !== 16'h7700 || bus0.inc_drop !== 1'b1) begin
            n_fail++; $display("FAIL conflict_drop: rdp %h drop %b want 7700 1", bus0.rdp, bus0.inc_drop);
        end
        bus0.inc_en = 1'b1; bus0.inc_sel = 2'(PAIR_DE);
        bus0.wr_en = 1'b1; bus0.wr_sel = 3'(REG_H); bus0.wr_data = 8'h55;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus0.inc_drop !== 1'b0 || bus0.rdp !== 16'h5500) begin
            n_fail++; $display("FAIL conflict_other_pair: drop %b rdp %h want 0 5500", bus0.inc_drop, bus0.rdp);
        end
        bus0.rdp_sel = 2'(PAIR_DE);
        #1;
        n_checks++;
        if (bus0.rdp !== 16'h0101) begin
            n_fail++; $display("FAIL conflict_inc_de: got %h want 0101", bus0.rdp);
        end
        bus0.wrp_en = 1'b1; bus0.wrp_sel = 2'(PAIR_HL); bus0.wrp_data = 16'hABCD;
        bus0.wr_en = 1'b1; bus0.wr_sel = 3'(REG_H); bus0.wr_data = 8'h11;
        tick();
        idle();
        bus0.rdp_sel = 2'(PAIR_HL);
        #1;
        n_checks++;
        if (bus0.rdp !== 16'hABCD) begin
            n_fail++; $display("FAIL priority_wrp: got %h want abcd", bus0.rdp);
        end
    endtask

    task automatic test_flag_mask();
        bus0.wr_en = 1'b1; bus0.wr_sel = 3'(REG_F); bus0.wr_data = 8'hFF;
        tick();
        idle();
        bus0.rd_a_sel = 3'(REG_F);
        #1;
        n_checks++;
        if (bus0.rd_a !== 8'hF0) begin
            n_fail++; $display("FAIL flag_byte: got %h want f0", bus0.rd_a);
        end
        bus0.wrp_en = 1'b1; bus0.wrp_sel = 2'(PAIR_AF); bus0.wrp_data = 16'h12FF;
        tick();
        idle();
        bus0.rdp_sel = 2'(PAIR_AF);
        #1;
        n_checks++;
        if (bus0.rdp !== 16'h10FF) begin
            n_fail++; $display("FAIL flag_pair: got %h want 10ff", bus0.rdp);
        end
        bus0.inc_en = 1'b1; bus0.inc_sel = 2'(PAIR_AF); bus0.inc_dec = INCDEC_INC;
        tick();
        idle();
        #1;
        n_checks++;
        if (bus0.rdp !== 16'h1000) begin
            n_fail++; $display("FAIL flag_inc: got %h want 1000", bus0.rdp);
        end
    endtask

    task automatic test_multi_write();
        bus0.wr_en = 1'b1; bus0.wr_sel = 3'(REG_B); bus0.wr_data = 8'h11;
        bus0.wrp_en = 1'b1; bus0.wrp_sel = 2'(PAIR_HL); bus0.wrp_data = 16'h2233;
        bus0.inc_en = 1'b1; bus0.inc_sel = 2'(PAIR_AF); bus0.inc_dec = INCDEC_INC;
        tick();
        idle();
        bus0.rd_a_sel = 3'(REG_B); bus0.rd_b_sel = 3'(REG_C); bus0.rdp_sel = 2'(PAIR_HL);
        #1;
        n_checks++;
        if (bus0.rd_a !== 8'h11 || bus0.rd_b !== 8'h00 || bus0.rdp !== 16'h2233 || bus0.inc_drop !== 1'b0) begin
            n_fail++; $display("FAIL multi_write: rd_a %h rd_b %h rdp %h drop %b want 11 00 2233 0", bus0.rd_a, bus0.rd_b, bus0.rdp, bus0.inc_drop);
        end
        bus0.rdp_sel = 2'(PAIR_AF);
        #1;
        n_checks++;
        if (bus0.rdp !== 16'h1001) begin
            n_fail++; $display("FAIL multi_inc_af: got %h want 1001", bus0.rdp);
        end
    endtask

    task automatic test_hold();
        idle();
        tick();
        tick();
        bus0.rdp_sel = 2'(PAIR_HL); bus0.rd_a_sel = 3'(REG_B);
        #1;
        n_checks++;
        if (bus0.rdp !== 16'h2233 || bus0.rd_a !== 8'h11) begin
            n_fail++; $display("FAIL hold: rdp %h rd_a %h want 2233 11", bus0.rdp, bus0.rd_a);
        end
    endtask

    task automatic test_bypass();
        bus0.wr_en = 1'b1; bus0.wr_sel = 3'(REG_B); bus0.wr_data = 8'h9C; bus0.rd_a_sel = 3'(REG_B);
        bus1.wr_en = 1'b1; bus1.wr_sel = 3'(REG_B); bus1.wr_data = 8'h9C; bus1.rd_a_sel = 3'(REG_B);
        bus1.inc_en = 1'b1; bus1.inc_sel = 2'(PAIR_DE); bus1.inc_dec = INCDEC_INC; bus1.rdp_sel = 2'(PAIR_DE);
        #1;
        n_checks++;
        if (bus1.rd_a !== 8'h9C || bus1.rdp !== 16'h0001) begin
            n_fail++; $display("FAIL bypass_pre: rd_a %h rdp %h want 9c 0001", bus1.rd_a, bus1.rdp);
        end
        n_checks++;
        if (bus0.rd_a !== 8'h11) begin
            n_fail++; $display("FAIL nobypass_pre: got %h want 11", bus0.rd_a);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (bus0.rd_a !== 8'h9C || bus1.rd_a !== 8'h9C || bus1.rdp !== 16'h0001) begin
            n_fail++; $display("FAIL bypass_post: rd0 %h rd1 %h rdp1 %h want 9c 9c 0001", bus0.rd_a, bus1.rd_a, bus1.rdp);
        end
        bus1.wr_en = 1'b1; bus1.wr_sel = 3'(REG_F); bus1.wr_data = 8'hFF; bus1.rd_b_sel = 3'(REG_F);
        #1;
        n_checks++;
        if (bus1.rd_b !== 8'hF0) begin
            n_fail++; $display("FAIL bypass_flag: got %h want f0", bus1.rd_b);
        end
        tick();
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle();
        bus0.rd_a_sel = '0; bus0.rd_b_sel = '0; bus0.rdp_sel = '0; bus0.wr_sel = '0; bus0.wr_data = '0;
        bus0.wrp_sel = '0; bus0.wrp_data = '0; bus0.inc_sel = '0;
        bus1.rd_a_sel = '0; bus1.rd_b_sel = '0; bus1.rdp_sel = '0; bus1.wr_sel = '0; bus1.wr_data = '0;
        bus1.wrp_sel = '0; bus1.wrp_data = '0; bus1.inc_sel = '0;
        test_reset();
        test_byte_pair();
        test_wrap();
        test_conflict();
        test_flag_mask();
        test_multi_write();
        test_hold();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
